// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event sequencer: event type codes,
// FSM state encoding and the FIFO entry packing helper.
package keypad_pkg;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } kp_state_e;

    // Entry layout seen by the host: {type, 2'b00, code}.
    function automatic logic [7:0] kp_entry(input logic [1:0] ev_type,
                                            input logic [3:0] code);
        return {ev_type, 2'b00, code};
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Event FIFO: one push and one pop per cycle; a pop frees room for a push in
// the same cycle, otherwise a push into a full FIFO is dropped and flagged.
module keypad_evt_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [7:0]                 din_i,
    output logic [7:0]                 dout_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          pop_ok;
    logic          push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && full_o && !pop_ok;
    assign count_o = count_q;
    assign dout_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Turns the scanner's level key-held indication into press/release/repeat
// events, queues them for the host and drives the active-low interrupt.
module keypad_event_ctrl
    import keypad_pkg::*;
#(
    parameter int               DEPTH         = 8,
    parameter int               CNT_W         = 24,
    parameter logic [CNT_W-1:0] REPEAT_DELAY  = 24'd12_000_000,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = 24'd2_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       key_int_n,
    input  logic [3:0]                 key_data,
    input  logic                       irq_en,
    input  logic                       rpt_en,
    input  logic                       rd_stb,
    input  logic                       clr_ovf,
    output logic [7:0]                 dout,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic                       irq_n
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = REPEAT_DELAY - 1'b1;
    localparam logic [CNT_W-1:0] PERIOD_LAST = REPEAT_PERIOD - 1'b1;

    kp_state_e         state_q, state_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [3:0]        code_q, code_d;
    logic              int_q;
    logic              ovf_q;
    logic              irq_n_q;

    logic              press_edge;
    logic              release_edge;
    logic              evt_push;
    logic [7:0]        evt_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_drop;

    assign press_edge   = int_q && !key_int_n;
    assign release_edge = !int_q && key_int_n;

    // Event decision is combinational so the push lands on the same edge
    // that first samples the key edge.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        code_d   = code_q;
        evt_push = 1'b0;
        evt_data = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (press_edge) begin
                    evt_push = 1'b1;
                    evt_data = kp_entry(EV_PRESS, key_data);
                    code_d   = key_data;
                    hcnt_d   = '0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (release_edge) begin
                    evt_push = 1'b1;
                    evt_data = kp_entry(EV_RELEASE, code_q);
                    hcnt_d   = '0;
                    state_d  = ST_IDLE;
                end else if (press_edge) begin
                    // Missed release: log it and restart the hold on the new code.
                    evt_push = 1'b1;
                    evt_data = kp_entry(EV_RELEASE, code_q);
                    code_d   = key_data;
                    hcnt_d   = '0;
                    state_d  = ST_HOLD;
                end else if (!rpt_en) begin
                    hcnt_d  = '0;
                    state_d = ST_HOLD;
                end else if (hcnt_q == ((state_q == ST_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
                    evt_push = 1'b1;
                    evt_data = kp_entry(EV_REPEAT, code_q);
                    hcnt_d   = '0;
                    state_d  = ST_REPEAT;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            code_q  <= 4'h0;
            int_q   <= 1'b1;
            ovf_q   <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            code_q  <= code_d;
            int_q   <= key_int_n;
            irq_n_q <= !(irq_en && !fifo_empty);
            if (fifo_drop && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    keypad_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (evt_push),
        .pop_i   (rd_stb),
        .din_i   (evt_data),
        .dout_o  (dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (count),
        .drop_o  (fifo_drop)
    );

    assign empty = fifo_empty;
    assign ovf   = ovf_q;
    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Bench for keypad_event_ctrl: directed scenarios plus randomized key holds
// checked against an event-list model of the keypad and host FIFO.
module tb_keypad_event_ctrl;

    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int DELAY  = 20;
    localparam int PERIOD = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_int_n = 1'b1;
    logic [3:0]    key_data = 4'h0;
    logic          irq_en = 1'b0;
    logic          rpt_en = 1'b0;
    logic          rd_stb = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [7:0]    dout;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          irq_n;

    int            checks = 0;
    int            failures = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    model_q[$];
    logic          m_ovf = 1'b0;
    logic [7:0]    mon_exp;

    always #5 clk = ~clk;

    keypad_event_ctrl #(
        .DEPTH         (DEPTH),
        .CNT_W         (24),
        .REPEAT_DELAY  (24'd20),
        .REPEAT_PERIOD (24'd5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_int_n (key_int_n),
        .key_data  (key_data),
        .irq_en    (irq_en),
        .rpt_en    (rpt_en),
        .rd_stb    (rd_stb),
        .clr_ovf   (clr_ovf),
        .dout      (dout),
        .empty     (empty),
        .count     (count),
        .ovf       (ovf),
        .irq_n     (irq_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ev(input logic [1:0] t, input logic [3:0] c);
        return {t, 2'b00, c};
    endfunction

    task automatic model_push(input logic [7:0] e);
        if (model_q.size() >= DEPTH) m_ovf = 1'b1;
        else model_q.push_back(e);
    endtask

    // A hold of len sampled-low cycles yields repeats at DELAY, DELAY+PERIOD, ...
    // strictly before the release edge at len.
    task automatic model_hold(input logic [3:0] code, input int len, input logic rpt);
        int n;
        n = (rpt && len > DELAY) ? (len - 1 - DELAY) / PERIOD + 1 : 0;
        model_push(ev(2'b01, code));
        for (int i = 0; i < n; i++) model_push(ev(2'b11, code));
        model_push(ev(2'b10, code));
    endtask

    task automatic hold(input logic [3:0] code, input int len);
        key_data  = code;
        key_int_n = 1'b0;
        repeat (len) tick();
        key_int_n = 1'b1;
        tick();
        model_hold(code, len, rpt_en);
    endtask

    task automatic rd();
        if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
        rd_stb = 1'b1;
        tick();
        rd_stb = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] head;
        tick();
        head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        check({tag, "_count"}, count, model_q.size());
        check({tag, "_ovf"}, ovf, m_ovf);
        check({tag, "_empty"}, empty, model_q.size() == 0);
        check({tag, "_head"}, dout, head);
        check({tag, "_irq_n"}, irq_n, !(irq_en && model_q.size() > 0));
    endtask

    task automatic drain(input string tag);
        while (model_q.size() > 0) rd();
        check_status(tag);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dout"}, dout, 8'h00);
        check({tag, "_empty"}, empty, 1'b1);
        check({tag, "_count"}, count, 0);
        check({tag, "_ovf"}, ovf, 1'b0);
        check({tag, "_irq_n"}, irq_n, 1'b1);
    endtask

    // Monitor: every accepted host read pops the expected entry.
    always @(negedge clk) begin
        if (rst && rd_stb) begin
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check("rd_dout", dout, mon_exp);
            end else begin
                check("rd_on_empty", empty, 1'b1);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b1;
        tick();

        // Press/release of code 5 without repeat, with latency checks.
        irq_en    = 1'b1;
        rpt_en    = 1'b0;
        key_data  = 4'h5;
        key_int_n = 1'b0;
        tick();
        check("t1_empty", empty, 1'b0);
        check("t1_dout", dout, 8'h45);
        check("t1_irq_lag", irq_n, 1'b1);
        tick();
        check("t1_irq_low", irq_n, 1'b0);
        repeat (8) tick();
        key_int_n = 1'b1;
        tick();
        model_hold(4'h5, 10, 1'b0);
        check("t1_count", count, 2);
        rd();
        check("t1_irq_after_rd1", irq_n, 1'b0);
        rd();
        check("t1_empty_after_rd2", empty, 1'b1);
        check("t1_irq_still_low", irq_n, 1'b0);
        tick();
        check("t1_irq_high", irq_n, 1'b1);

        // Auto-repeat timing: press, repeats at +20/+25/+30, release.
        rpt_en    = 1'b1;
        key_data  = 4'hA;
        key_int_n = 1'b0;
        tick();
        check("t2_press", count, 1);
        for (int k = 1; k < 32; k++) begin
            tick();
            check("t2_count", count, 1 + ((k >= DELAY) ? (k - DELAY) / PERIOD + 1 : 0));
        end
        key_int_n = 1'b1;
        tick();
        check("t2_final", count, 5);
        model_hold(4'hA, 32, 1'b1);
        check_status("t2");
        drain("t2_drain");

        // Overflow: nine press/release pairs of code 3, no reads.
        rpt_en = 1'b0;
        repeat (9) hold(4'h3, 2);
        check("t3_count", count, 8);
        check("t3_ovf", ovf, 1'b1);
        check("t3_head", dout, 8'h43);
        check_status("t3");
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        m_ovf   = 1'b0;
        check("t3_ovf_clr", ovf, 1'b0);

        // Full FIFO: read and release edge in the same cycle.
        rd();
        key_data  = 4'h3;
        key_int_n = 1'b0;
        tick();
        model_push(ev(2'b01, 4'h3));
        check("t4_full", count, 8);
        repeat (2) tick();
        exp_q.push_back(model_q.pop_front());
        model_push(ev(2'b10, 4'h3));
        key_int_n = 1'b1;
        rd_stb    = 1'b1;
        tick();
        rd_stb = 1'b0;
        check("t4_count", count, 8);
        check("t4_ovf", ovf, 1'b0);
        check_status("t4");
        drain("t4_drain");

        // Interrupt enable gating.
        irq_en = 1'b0;
        hold(4'h7, 3);
        check_status("t5");
        check("t5_irq_off", irq_n, 1'b1);
        irq_en = 1'b1;
        tick();
        check("t5_irq_on", irq_n, 1'b0);
        drain("t5_drain");

        // Reset while repeating with three entries queued, key still held.
        rpt_en    = 1'b1;
        key_data  = 4'h9;
        key_int_n = 1'b0;
        repeat (26) tick();
        check("t6_pre_count", count, 3);
        rst = 1'b0;
        #1;
        check_reset("t6_rst");
        model_q.delete();
        m_ovf  = 1'b0;
        rpt_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t6_press_count", count, 1);
        check("t6_press_dout", dout, 8'h49);
        repeat (3) tick();
        check("t6_single", count, 1);
        model_push(ev(2'b01, 4'h9));
        key_int_n = 1'b1;
        tick();
        model_push(ev(2'b10, 4'h9));
        check_status("t6");
        drain("t6_drain");

        // Randomized holds with interleaved host activity.
        for (int it = 0; it < 40; it++) begin
            int nrd;
            rpt_en = 1'($urandom_range(0, 1));
            irq_en = ($urandom_range(0, 3) != 0);
            hold(4'($urandom_range(0, 15)), $urandom_range(1, 35));
            nrd = $urandom_range(0, 4);
            for (int r = 0; r < nrd; r++) rd();
            if ($urandom_range(0, 5) == 0) begin
                clr_ovf = 1'b1;
                tick();
                clr_ovf = 1'b0;
                m_ovf   = 1'b0;
            end
            check_status("rnd");
        end
        irq_en = 1'b1;
        drain("end_drain");
        check("exp_q_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
